// File: rtl/cordic_rotate.sv
`timescale 1ns/1ps
// cordic_rotate: buffers a burst of up to 16 polar samples, then converts each to
// rectangular form with a 16-step CORDIC. Define CORDIC_ROTATE_SAT_EN to saturate outputs.
module cordic_rotate (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [11:0] in_mag,
   input  logic [20:0] in_phase,
   output logic        out_valid,
   output logic [11:0] out_x,
   output logic [11:0] out_y
);

   localparam logic [13:0] INV_K = 14'b10011011011101;

   typedef enum logic [2:0] {IDLE, IN, LOAD, ITER, STORE, OUT} state_t;

   state_t state, state_next;

   logic [4:0] cnt;
   logic [3:0] proc_idx;
   logic [3:0] iter;
   logic [3:0] out_idx;
   logic       last_sample;
   logic       last_out;
   logic       buf_we;
   logic [3:0] wr_addr;

   logic [11:0] mag_buf   [16];
   logic [20:0] phase_buf [16];
   logic [11:0] res_x_buf [16];
   logic [11:0] res_y_buf [16];

   logic signed [21:0] x, y, z;
   logic signed [21:0] atan_val;
   logic signed [21:0] mag_ext;
   logic signed [36:0] prod_x, prod_y;
   logic [11:0]        res_x, res_y;

   assign last_sample = ({1'b0, proc_idx} == cnt - 5'd1);
   assign last_out    = ({1'b0, out_idx} == cnt - 5'd1);
   assign buf_we      = in_valid && ((state == IDLE) || ((state == IN) && (cnt != 5'd16)));
   assign wr_addr     = (state == IDLE) ? 4'd0 : cnt[3:0];
   assign mag_ext     = {6'b000000, mag_buf[proc_idx], 4'b0000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = IN;
         IN:      if (!in_valid) state_next = LOAD;
         LOAD:    state_next = ITER;
         ITER:    if (iter == 4'd15) state_next = STORE;
         STORE:   state_next = last_sample ? OUT : LOAD;
         OUT:     if (last_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Sample count, compute pointer, iteration index and output pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 5'd0;
         proc_idx <= 4'd0;
         iter     <= 4'd0;
         out_idx  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               cnt      <= in_valid ? 5'd1 : 5'd0;
               proc_idx <= 4'd0;
               iter     <= 4'd0;
               out_idx  <= 4'd0;
            end
            IN:      if (in_valid && (cnt != 5'd16)) cnt <= cnt + 5'd1;
            LOAD:    iter <= 4'd0;
            ITER:    iter <= iter + 4'd1;
            STORE:   if (!last_sample) proc_idx <= proc_idx + 4'd1;
            OUT:     out_idx <= out_idx + 4'd1;
            default: ;
         endcase
      end
   end

   // atan(2^-i) with 1.0 = 180 degrees and 20 fractional bits
   always_comb begin
      atan_val = 22'sd0;
      case (iter)
         4'd0:  atan_val = 22'sh040000;
         4'd1:  atan_val = 22'sh025C81;
         4'd2:  atan_val = 22'sh013F67;
         4'd3:  atan_val = 22'sh00A222;
         4'd4:  atan_val = 22'sh005162;
         4'd5:  atan_val = 22'sh0028BB;
         4'd6:  atan_val = 22'sh00145F;
         4'd7:  atan_val = 22'sh000A30;
         4'd8:  atan_val = 22'sh000518;
         4'd9:  atan_val = 22'sh00028C;
         4'd10: atan_val = 22'sh000146;
         4'd11: atan_val = 22'sh0000A3;
         4'd12: atan_val = 22'sh000051;
         4'd13: atan_val = 22'sh000029;
         4'd14: atan_val = 22'sh000014;
         default: atan_val = 22'sh00000A;
      endcase
   end

`ifdef CORDIC_ROTATE_SAT_EN
   function automatic logic [11:0] sat12(input logic signed [36:0] v);
      if (v > 37'sd2047)       return 12'h7FF;
      else if (v < -37'sd2048) return 12'h800;
      else                     return 12'(v);
   endfunction
`endif

   // Undo the CORDIC gain; the shift by 18 drops 12+14-8 fractional bits (floor)
   always_comb begin
      prod_x = {{15{x[21]}}, x} * 37'(INV_K);
      prod_y = {{15{y[21]}}, y} * 37'(INV_K);
`ifdef CORDIC_ROTATE_SAT_EN
      res_x = sat12(prod_x >>> 18);
      res_y = sat12(prod_y >>> 18);
`else
      res_x = 12'(prod_x >>> 18);
      res_y = 12'(prod_y >>> 18);
`endif
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         mag_buf[wr_addr]   <= in_mag;
         phase_buf[wr_addr] <= in_phase;
      end
      case (state)
         LOAD: begin
            case (phase_buf[proc_idx][20:19])
               2'd0:    begin x <= mag_ext;  y <= 22'sd0;   end
               2'd1:    begin x <= 22'sd0;   y <= mag_ext;  end
               2'd2:    begin x <= -mag_ext; y <= 22'sd0;   end
               default: begin x <= 22'sd0;   y <= -mag_ext; end
            endcase
            z <= {3'b000, phase_buf[proc_idx][18:0]};
         end
         ITER: begin
            if (!z[21]) begin
               x <= x - (y >>> iter);
               y <= y + (x >>> iter);
               z <= z - atan_val;
            end else begin
               x <= x + (y >>> iter);
               y <= y - (x >>> iter);
               z <= z + atan_val;
            end
         end
         STORE: begin
            res_x_buf[proc_idx] <= res_x;
            res_y_buf[proc_idx] <= res_y;
         end
         default: ;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT);
      out_x     = 12'h000;
      out_y     = 12'h000;
      if (state == OUT) begin
         out_x = res_x_buf[out_idx];
         out_y = res_y_buf[out_idx];
      end
   end

endmodule
